// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register (hold / shift right /
//            shift left / parallel load) with a saturating shift counter.
//            Optional macro UNIV_SHIFT_REG_ROTATE_EN turns shifts into rotates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  localparam logic [1:0]    c_MODE_HOLD = 2'b00;
  localparam logic [1:0]    c_MODE_SHR  = 2'b01;
  localparam logic [1:0]    c_MODE_SHL  = 2'b10;
  localparam logic [1:0]    c_MODE_LOAD = 2'b11;
  localparam logic [CW-1:0] c_CNT_MAX   = CW'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             w_ser_r;
  logic             w_ser_l;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic             w_sat;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  // Rotate: the bit leaving one end re-enters the other; serial inputs unused.
  assign w_ser_r = r_q[0];
  assign w_ser_l = r_q[WIDTH-1];
`else
  assign w_ser_r = sin_r;
  assign w_ser_l = sin_l;
`endif

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shr = w_ser_r;
      assign w_shl = w_ser_l;
    end else begin : g_wn
      assign w_shr = {w_ser_r, r_q[WIDTH-1:1]};
      assign w_shl = {r_q[WIDTH-2:0], w_ser_l};
    end
  endgenerate

  assign w_sat = (r_cnt == c_CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q   <= RESET_VALUE;
      r_cnt <= '0;
    end else begin
      case (mode)
        c_MODE_HOLD: begin
          r_q   <= r_q;
          r_cnt <= r_cnt;
        end
        c_MODE_SHR: begin
          r_q   <= w_shr;
          r_cnt <= w_sat ? r_cnt : r_cnt + CW'(1);
        end
        c_MODE_SHL: begin
          r_q   <= w_shl;
          r_cnt <= w_sat ? r_cnt : r_cnt + CW'(1);
        end
        c_MODE_LOAD: begin
          r_q   <= d;
          r_cnt <= '0;
        end
        default: begin
          r_q   <= r_q;
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign q         = r_q;
  assign sout_r    = r_q[0];
  assign sout_l    = r_q[WIDTH-1];
  assign shift_cnt = r_cnt;
  assign done      = w_sat;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VALUE=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  localparam int c_W  = 8;
  localparam int c_CW = 4;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      mode;
  logic            sin_r;
  logic            sin_l;
  logic [c_W-1:0]  d;
  logic [c_W-1:0]  q;
  logic            sout_r;
  logic            sout_l;
  logic [c_CW-1:0] shift_cnt;
  logic            done;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  univ_shift_reg #(.WIDTH(c_W), .RESET_VALUE(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .d         (d),
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge's worth of inputs and queue the state expected after it.
  task automatic step(input logic rn, input logic [1:0] m, input logic [7:0] dd,
                      input logic sr, input logic sl,
                      input logic [7:0] eq, input logic [3:0] ec, input logic ed);
    exp_t e;
    @(negedge clk);
    reset = rn; mode = m; d = dd; sin_r = sr; sin_l = sl;
    e.q = eq; e.cnt = ec; e.done = ed;
    sb.push_back(e);
  endtask

  // Monitor: the register presents a new result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q",      32'(q),         32'(e.q));
        chk("cnt",    32'(shift_cnt), 32'(e.cnt));
        chk("done",   32'(done),      32'(e.done));
        chk("sout_r", 32'(sout_r),    32'(e.q[0]));
        chk("sout_l", 32'(sout_l),    32'(e.q[7]));
      end
    end
  end

  logic [7:0] shl_q [9];
  logic [7:0] rst_shr_q;
  logic [7:0] mix_q [3];

  initial begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    shl_q     = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
    rst_shr_q = 8'h00;
    mix_q     = '{8'h03, 8'h81, 8'hC0};
`else
    shl_q     = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00};
    rst_shr_q = 8'h80;
    mix_q     = '{8'h02, 8'h01, 8'h00};
`endif
    reset = 1'b1; mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0;

    // Reset beats a simultaneous load
    step(1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    // Load then one right shift
    step(1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hD2, 4'd1, 1'b0);
    // Nine left shifts: counter saturates at WIDTH
    step(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'h81, 4'd0, 1'b0);
    for (int i = 0; i < 9; i++)
      step(1'b1, 2'b10, 8'hFF, 1'b1, 1'b0, shl_q[i],
           (i < 8) ? 4'(i + 1) : 4'd8, (i >= 7));
    // Load while done is high, then hold with noisy unused inputs
    step(1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'd0, 1'b0);
    step(1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 8'h3C, 4'd0, 1'b0);
    step(1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 8'h3C, 4'd0, 1'b0);
    step(1'b1, 2'b00, 8'hAA, 1'b1, 1'b0, 8'h3C, 4'd0, 1'b0);
    // Reset mid-sequence
    step(1'b1, 2'b11, 8'hF0, 1'b0, 1'b0, 8'hF0, 4'd0, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'h78, 4'd1, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'h3C, 4'd2, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'h1E, 4'd3, 1'b0);
    step(1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b1, 1'b0, rst_shr_q, 4'd1, 1'b0);
    // Mixed directions share the counter
    step(1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 8'h81, 4'd0, 1'b0);
    step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, mix_q[0], 4'd1, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, mix_q[1], 4'd2, 1'b0);
    step(1'b1, 2'b01, 8'h00, 1'b0, 1'b0, mix_q[2], 4'd3, 1'b0);
    // Parallel-load an all-ones word
    step(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 8'hFF, 4'd0, 1'b0);
    step(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'hFF, 4'd0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
